// File: rtl/mem_rw_checker.sv
// mem_rw_checker
//   Write-then-readback traffic generator and self-checker for a memory model
//   with one write port and one read port. Each pass writes DEPTH locations
//   with pattern(addr) = addr + SEED + pass_cnt, reads them back, and checks
//   each returned word RD_DATA_DLY cycles after its read strobe. The first
//   mismatch is captured; completed passes are counted.
//
// Ports
//   clk, rstN         : clock (rising edge), async active-low reset
//   start             : begin a run (sampled only when idle)
//   stop              : abort to idle from any state, drops in-flight reads
//   loop_en           : run passes back-to-back until stop
//   mem_write/_addr_wr/_data_wr : write port to the memory
//   mem_read/_addr_rd : read strobe and address to the memory
//   mem_data_rd       : read data returned by the memory
//   busy, done        : not idle / one-cycle end-of-pass pulse
//   err, err_addr, err_expected, err_actual : sticky first-mismatch record
//   pass_cnt          : completed passes, wraps at 2^16
module mem_rw_checker #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    DEPTH       = 256,
  parameter int                    RD_DATA_DLY = 0,
  parameter logic [DATA_WIDTH-1:0] SEED        = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr_rd,
  input  logic [DATA_WIDTH-1:0] mem_data_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_expected,
  output logic [DATA_WIDTH-1:0] err_actual,
  output logic [15:0]           pass_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int                    STAGES = RD_DATA_DLY;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);
  // Only reached when STAGES > 0, so the wrap for STAGES == 0 is harmless.
  localparam logic [1:0]            DRN_LAST = 2'(STAGES - 1);

  // A read travels with its address and the pass number it was issued in,
  // so a compare that lands after pass_cnt has moved still uses the right
  // expected pattern.
  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           pcnt;
  } rd_tag_t;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [1:0]            drn_cnt;

  rd_tag_t               tag_in;
  rd_tag_t               tag_out;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [15:0]           pc
  );
    pattern = DATA_WIDTH'(a) + SEED + DATA_WIDTH'(pc);
  endfunction

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------
  // Read tag pipe: STAGES deep, flushed by stop.
  // ---------------------------------------------------------------------
  assign tag_in = {mem_read, mem_addr_rd, pass_cnt};

  generate
    if (STAGES == 0) begin : g_nodly
      assign tag_out = tag_in;
    end else begin : g_dly
      rd_tag_t tag_pipe [STAGES];

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          for (int k = 0; k < STAGES; k++) tag_pipe[k] <= '0;
        end else begin
          tag_pipe[0] <= stop ? '0 : tag_in;
          for (int k = 1; k < STAGES; k++)
            tag_pipe[k] <= stop ? '0 : tag_pipe[k-1];
        end
      end

      assign tag_out = tag_pipe[STAGES-1];
    end
  endgenerate

  // Compare against the live read data; stop drops whatever is arriving.
  assign cmp_vld  = tag_out.vld & ~stop;
  assign exp_data = pattern(tag_out.addr, tag_out.pcnt);
  assign mismatch = cmp_vld && (mem_data_rd != exp_data);

  // ---------------------------------------------------------------------
  // Sequencer. `state` names what the registered strobes show this cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= S_IDLE;
      cnt          <= '0;
      drn_cnt      <= '0;
      mem_write    <= 1'b0;
      mem_addr_wr  <= '0;
      mem_data_wr  <= '0;
      mem_read     <= 1'b0;
      mem_addr_rd  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      pass_cnt     <= '0;
    end else begin
      done <= 1'b0;

      // First mismatch only; the start branch below overrides when clearing.
      if (mismatch && !err) begin
        err          <= 1'b1;
        err_addr     <= tag_out.addr;
        err_expected <= exp_data;
        err_actual   <= mem_data_rd;
      end

      if (stop) begin
        state     <= S_IDLE;
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_WRITE;
              cnt          <= '0;
              mem_write    <= 1'b1;
              mem_addr_wr  <= '0;
              mem_data_wr  <= pattern('0, 16'd0);
              err          <= 1'b0;
              err_addr     <= '0;
              err_expected <= '0;
              err_actual   <= '0;
              pass_cnt     <= '0;
            end
          end

          S_WRITE: begin
            if (cnt == LAST) begin
              state       <= S_READ;
              cnt         <= '0;
              mem_write   <= 1'b0;
              mem_read    <= 1'b1;
              mem_addr_rd <= '0;
            end else begin
              cnt         <= cnt + 1'b1;
              mem_addr_wr <= cnt + 1'b1;
              mem_data_wr <= pattern(cnt + 1'b1, pass_cnt);
            end
          end

          S_READ: begin
            if (cnt == LAST) begin
              cnt      <= '0;
              mem_read <= 1'b0;
              drn_cnt  <= '0;
              if (STAGES > 0) begin
                state <= S_DRAIN;
              end else begin
                state    <= S_DONE;
                done     <= 1'b1;
                pass_cnt <= pass_cnt + 1'b1;
              end
            end else begin
              cnt         <= cnt + 1'b1;
              mem_addr_rd <= cnt + 1'b1;
            end
          end

          S_DRAIN: begin
            // The last read's data lands in the final drain cycle.
            if (drn_cnt == DRN_LAST) begin
              state    <= S_DONE;
              done     <= 1'b1;
              pass_cnt <= pass_cnt + 1'b1;
            end else begin
              drn_cnt <= drn_cnt + 1'b1;
            end
          end

          S_DONE: begin
            if (loop_en) begin
              state       <= S_WRITE;
              cnt         <= '0;
              mem_write   <= 1'b1;
              mem_addr_wr <= '0;
              // pass_cnt already advanced on entry to DONE.
              mem_data_wr <= pattern('0, pass_cnt);
            end else begin
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_rw_checker.sv
// tb_mem_rw_checker
//   Directed bench for mem_rw_checker. Three instances with DEPTH=4:
//     u_a : RD_DATA_DLY=0, SEED=0  (basic pass, double mismatch, stop in DONE, reset mid-write)
//     u_b : RD_DATA_DLY=2, SEED=0  (addr 2 returns 16'hDEAD)
//     u_c : RD_DATA_DLY=3, SEED=10 (three looped passes, stop in READ with garbage after)
//   Each has a small memory model with the matching read latency.
//   Cycle k is the cycle after the k-th rising edge following start; outputs
//   are sampled on the falling edge.
module tb_mem_rw_checker;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic        a_start, a_stop, a_loop;
  logic        a_mem_write, a_mem_read, a_busy, a_done, a_err;
  logic [15:0] a_mem_addr_wr, a_mem_data_wr, a_mem_addr_rd, a_mem_data_rd;
  logic [15:0] a_err_addr, a_err_expected, a_err_actual, a_pass_cnt;
  logic [15:0] a_mem [4];
  logic [3:0]  a_corrupt;

  always @(posedge clk) if (a_mem_write) a_mem[a_mem_addr_wr[1:0]] <= a_mem_data_wr;
  assign a_mem_data_rd = a_corrupt[a_mem_addr_rd[1:0]] ? (a_mem[a_mem_addr_rd[1:0]] ^ 16'h00F0)
                                                       : a_mem[a_mem_addr_rd[1:0]];

  mem_rw_checker #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .RD_DATA_DLY(0), .SEED(16'd0)) u_a (
    .clk(clk), .rstN(rstN), .start(a_start), .stop(a_stop), .loop_en(a_loop),
    .mem_write(a_mem_write), .mem_addr_wr(a_mem_addr_wr), .mem_data_wr(a_mem_data_wr),
    .mem_read(a_mem_read), .mem_addr_rd(a_mem_addr_rd), .mem_data_rd(a_mem_data_rd),
    .busy(a_busy), .done(a_done), .err(a_err), .err_addr(a_err_addr),
    .err_expected(a_err_expected), .err_actual(a_err_actual), .pass_cnt(a_pass_cnt));

  // ---------------- instance B ----------------
  logic        b_start, b_stop, b_loop;
  logic        b_mem_write, b_mem_read, b_busy, b_done, b_err;
  logic [15:0] b_mem_addr_wr, b_mem_data_wr, b_mem_addr_rd, b_mem_data_rd;
  logic [15:0] b_err_addr, b_err_expected, b_err_actual, b_pass_cnt;
  logic [15:0] b_mem [4];
  logic [15:0] b_rq  [2];

  always @(posedge clk) begin
    if (b_mem_write) b_mem[b_mem_addr_wr[1:0]] <= b_mem_data_wr;
    b_rq[0] <= (b_mem_addr_rd[1:0] == 2'd2) ? 16'hDEAD : b_mem[b_mem_addr_rd[1:0]];
    b_rq[1] <= b_rq[0];
  end
  assign b_mem_data_rd = b_rq[1];

  mem_rw_checker #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .RD_DATA_DLY(2), .SEED(16'd0)) u_b (
    .clk(clk), .rstN(rstN), .start(b_start), .stop(b_stop), .loop_en(b_loop),
    .mem_write(b_mem_write), .mem_addr_wr(b_mem_addr_wr), .mem_data_wr(b_mem_data_wr),
    .mem_read(b_mem_read), .mem_addr_rd(b_mem_addr_rd), .mem_data_rd(b_mem_data_rd),
    .busy(b_busy), .done(b_done), .err(b_err), .err_addr(b_err_addr),
    .err_expected(b_err_expected), .err_actual(b_err_actual), .pass_cnt(b_pass_cnt));

  // ---------------- instance C ----------------
  logic        c_start, c_stop, c_loop, c_garbage;
  logic        c_mem_write, c_mem_read, c_busy, c_done, c_err;
  logic [15:0] c_mem_addr_wr, c_mem_data_wr, c_mem_addr_rd, c_mem_data_rd;
  logic [15:0] c_err_addr, c_err_expected, c_err_actual, c_pass_cnt;
  logic [15:0] c_mem [4];
  logic [15:0] c_rq  [3];

  always @(posedge clk) begin
    if (c_mem_write) c_mem[c_mem_addr_wr[1:0]] <= c_mem_data_wr;
    c_rq[0] <= c_mem[c_mem_addr_rd[1:0]];
    c_rq[1] <= c_rq[0];
    c_rq[2] <= c_rq[1];
  end
  assign c_mem_data_rd = c_garbage ? 16'hBEEF : c_rq[2];

  mem_rw_checker #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .RD_DATA_DLY(3), .SEED(16'd10)) u_c (
    .clk(clk), .rstN(rstN), .start(c_start), .stop(c_stop), .loop_en(c_loop),
    .mem_write(c_mem_write), .mem_addr_wr(c_mem_addr_wr), .mem_data_wr(c_mem_data_wr),
    .mem_read(c_mem_read), .mem_addr_rd(c_mem_addr_rd), .mem_data_rd(c_mem_data_rd),
    .busy(c_busy), .done(c_done), .err(c_err), .err_addr(c_err_addr),
    .err_expected(c_err_expected), .err_actual(c_err_actual), .pass_cnt(c_pass_cnt));

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    a_start = 0; a_stop = 0; a_loop = 0; a_corrupt = '0;
    b_start = 0; b_stop = 0; b_loop = 0;
    c_start = 0; c_stop = 0; c_loop = 0; c_garbage = 0;
    for (int i = 0; i < 4; i++) begin a_mem[i] = '0; b_mem[i] = '0; c_mem[i] = '0; end
    b_rq[0] = '0; b_rq[1] = '0;
    c_rq[0] = '0; c_rq[1] = '0; c_rq[2] = '0;

    // ---- reset state ----
    #1;
    chk("rst_wr",    a_mem_write, 0);
    chk("rst_rd",    a_mem_read, 0);
    chk("rst_awr",   a_mem_addr_wr, 0);
    chk("rst_dwr",   a_mem_data_wr, 0);
    chk("rst_ard",   a_mem_addr_rd, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_eaddr", a_err_addr, 0);
    chk("rst_pcnt",  a_pass_cnt, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_c_busy", c_busy, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // ---- T1: basic pass on A; start pulse in cycle 3 is ignored ----
    a_start = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      a_start = (k == 3);
      chk("t1_wr", a_mem_write, k <= 4);
      if (k <= 4) begin
        chk("t1_awr", a_mem_addr_wr, k - 1);
        chk("t1_dwr", a_mem_data_wr, k - 1);
      end
      chk("t1_rd", a_mem_read, (k >= 5 && k <= 8));
      if (k >= 5 && k <= 8) chk("t1_ard", a_mem_addr_rd, k - 5);
      chk("t1_done", a_done, k == 9);
      chk("t1_busy", a_busy, k <= 9);
    end
    a_start = 0;
    chk("t1_err",  a_err, 0);
    chk("t1_pcnt", a_pass_cnt, 1);

    // ---- T4: mismatches at addr 1 and 3, first is kept ----
    a_corrupt = 4'b1010;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (9) @(negedge clk);
    chk("t4_err",   a_err, 1);
    chk("t4_eaddr", a_err_addr, 1);
    chk("t4_eexp",  a_err_expected, 1);
    chk("t4_eact",  a_err_actual, 16'h00F1);
    chk("t4_pcnt",  a_pass_cnt, 1);
    chk("t4_busy",  a_busy, 0);
    a_corrupt = '0;

    // ---- T7: stop during the DONE cycle with loop_en set ----
    a_loop = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (8) @(negedge clk);   // cycle 9
    a_stop = 1;
    chk("t7_done", a_done, 1);
    chk("t7_pcnt", a_pass_cnt, 1);
    @(negedge clk);              // cycle 10
    a_stop = 0;
    chk("t7_busy", a_busy, 0);
    chk("t7_wr",   a_mem_write, 0);
    chk("t7_pcnt2", a_pass_cnt, 1);
    a_loop = 0;

    // ---- T6: reset dropped mid-write, then a clean pass ----
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    @(negedge clk);              // cycle 2
    chk("t6_wr_pre", a_mem_write, 1);
    rstN = 1'b0;
    #1;
    chk("t6_wr",   a_mem_write, 0);
    chk("t6_busy", a_busy, 0);
    chk("t6_awr",  a_mem_addr_wr, 0);
    chk("t6_dwr",  a_mem_data_wr, 0);
    chk("t6_pcnt", a_pass_cnt, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle", a_busy, 0);
    chk("t6_idle_wr", a_mem_write, 0);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (8) @(negedge clk);   // cycle 9
    chk("t6_done", a_done, 1);
    @(negedge clk);
    chk("t6_err",  a_err, 0);
    chk("t6_pcnt2", a_pass_cnt, 1);
    chk("t6_busy2", a_busy, 0);

    // ---- T2: B, latency 2, addr 2 corrupted ----
    b_start = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      b_start = 0;
      chk("t2_rd",   b_mem_read, (k >= 5 && k <= 8));
      chk("t2_done", b_done, k == 11);
    end
    chk("t2_err",   b_err, 1);
    chk("t2_eaddr", b_err_addr, 2);
    chk("t2_eexp",  b_err_expected, 2);
    chk("t2_eact",  b_err_actual, 16'hDEAD);
    chk("t2_pcnt",  b_pass_cnt, 1);
    chk("t2_busy",  b_busy, 0);

    // ---- T3: C, SEED=10, three looped passes of 12 cycles each ----
    c_loop = 1;
    c_start = 1;
    for (int k = 1; k <= 38; k++) begin
      int p, off;
      logic wr_exp;
      @(negedge clk);
      c_start = 0;
      if (k == 30) c_loop = 0;
      p      = (k - 1) / 12;
      off    = (k - 1) % 12;
      wr_exp = (k <= 36) && (off < 4);
      chk("t3_wr", c_mem_write, wr_exp);
      if (wr_exp) chk("t3_dwr", c_mem_data_wr, 10 + p + off);
      chk("t3_done", c_done, (k == 12 || k == 24 || k == 36));
      chk("t3_excl", c_mem_write & c_mem_read, 0);
    end
    chk("t3_pcnt", c_pass_cnt, 3);
    chk("t3_err",  c_err, 0);
    chk("t3_busy", c_busy, 0);

    // ---- T5: C, stop in READ, memory returns garbage afterwards ----
    c_start = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      c_start = 0;
      if (k == 5) chk("t5_rd_pre", c_mem_read, 1);
      if (k == 6) begin
        c_stop = 1;
        c_garbage = 1;
      end else begin
        c_stop = 0;
      end
      if (k == 7) begin
        chk("t5_busy", c_busy, 0);
        chk("t5_rd",   c_mem_read, 0);
      end
      chk("t5_done", c_done, 0);
    end
    chk("t5_err",  c_err, 0);
    chk("t5_pcnt", c_pass_cnt, 0);
    c_garbage = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_rw_checker.md
# mem_rw_checker

Parametrised write-then-readback traffic generator and self-checker for a single-read/single-write memory model (mpram-style port set). It fills `DEPTH` locations with an address-derived pattern, reads them back with a configurable read-data latency, and compares every returned word against the expected value. It records the first mismatch and counts completed passes. It sits in lemma-check benches in place of hand-written counter stimulus, so memory-model properties are checked across width, depth and latency variants.

## Interface
- `ADDR_WIDTH`, 16, memory address width.
- `DATA_WIDTH`, 16, memory data width.
- `DEPTH`, 256, locations exercised per pass (addresses 0..DEPTH-1); legal range 2..2^ADDR_WIDTH.
- `RD_DATA_DLY`, 0, cycles from `mem_read` to valid `mem_data_rd`; legal range 0..3.
- `SEED`, 0, DATA_WIDTH-bit pattern offset.
- `clk` in 1: single clock, rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; sampled only in IDLE.
- `stop` in 1: abort from any state.
- `loop_en` in 1: run passes back-to-back until `stop`.
- `mem_write` out 1: write strobe.
- `mem_addr_wr` out ADDR_WIDTH: write address.
- `mem_data_wr` out DATA_WIDTH: write data.
- `mem_read` out 1: read strobe.
- `mem_addr_rd` out ADDR_WIDTH: read address.
- `mem_data_rd` in DATA_WIDTH: read data from the memory.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at the end of each pass.
- `err` out 1: sticky mismatch flag.
- `err_addr` out ADDR_WIDTH: address of the first mismatch.
- `err_expected` out DATA_WIDTH: expected data at the first mismatch.
- `err_actual` out DATA_WIDTH: returned data at the first mismatch.
- `pass_cnt` out 16: completed passes; wraps at 2^16.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE → WRITE on `start`. Entering from IDLE clears `err`, `err_*` and `pass_cnt`.
- WRITE: one write per cycle. Address counter runs 0..DEPTH-1. `mem_data_wr = pattern(addr)`. After address DEPTH-1 the FSM goes to READ and the counter resets to 0.
- READ: one read per cycle, addresses 0..DEPTH-1. Each read pushes (valid, addr) into a RD_DATA_DLY-deep tag pipe.
  - After DEPTH-1, go to DRAIN if RD_DATA_DLY>0, else go to DONE.
- DRAIN: stays exactly RD_DATA_DLY cycles, then goes to DONE.
- DONE: one cycle. Asserts `done` and increments `pass_cnt`. Next state is WRITE if `loop_en`, else IDLE.
- pattern(a) = (zero-extend or truncate a to DATA_WIDTH) + SEED + pass_cnt, mod 2^DATA_WIDTH. Each pass therefore writes different data.
- Compare: when the tag pipe output is valid, compare `mem_data_rd` with pattern(tag addr), using the pass_cnt value in effect when that read was issued.
  - RD_DATA_DLY=0: compare in the same cycle as `mem_read`.
  - First mismatch only: set `err` and capture `err_addr`, `err_expected`, `err_actual`. Later mismatches leave the captured values unchanged.
- `stop` has priority over every other transition. Next state is IDLE, the tag pipe is flushed, and outstanding reads are not compared. `err` and `pass_cnt` hold.
- `start` while busy is ignored.
- `mem_addr_wr`, `mem_data_wr` and `mem_addr_rd` hold their last value when the corresponding strobe is low.

## Timing
- Reset (`rstN`=0, asynchronous) forces IDLE and clears all outputs, counters and the tag pipe: `mem_write`=`mem_read`=0, addresses/data=0, `busy`=`done`=`err`=0, `err_*`=0, `pass_cnt`=0.
- All outputs are registered, except that the compare result is taken from `mem_data_rd` on the compare cycle.
- `start` sampled at edge E0: `mem_write` is high for cycles 1..DEPTH and `mem_read` for cycles DEPTH+1..2·DEPTH. `done` is high in cycle 2·DEPTH+RD_DATA_DLY+1.
- With `loop_en`, the next pass's first write is in the cycle after `done`. There are no idle cycles between passes.
- `mem_write` and `mem_read` are never high in the same cycle.
- Reset released mid-pass: the block restarts only on a new `start`.
- `stop` and the DONE cycle coinciding: `done` still pulses and `pass_cnt` increments; next state is IDLE.

## Test plan
- DEPTH=4, RD_DATA_DLY=0, SEED=0, ideal memory, `start` pulse → writes addr 0..3 with data 0..3, reads 0..3. `done` pulses at cycle 9, `err`=0, `pass_cnt`=1, then IDLE.
- DEPTH=4, RD_DATA_DLY=2, memory corrupts addr 2 to 16'hDEAD → `err`=1, `err_addr`=2, `err_expected`=2, `err_actual`=16'hDEAD. `done` at cycle 11.
- `loop_en`=1, DEPTH=4, SEED=10, three passes → pass 2 writes 11..14 and pass 3 writes 12..15, no error, `pass_cnt`=3 after the third `done`.
- Mismatches at addr 1 and addr 3 in the same pass → captured `err_addr` stays 1.
- `stop` asserted in READ with RD_DATA_DLY=3 and the memory returning garbage afterwards → IDLE next cycle, no compare, `err`=0, no `done`.
- `rstN` dropped mid-WRITE → all outputs 0 immediately. A `start` after release runs a full clean pass with `pass_cnt`=1.
